multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the 32-bit RV32I-subset datapath (fetch unit, decode/register file, ALU execute stage, data memory). It holds a copy of the current instruction and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives every datapath enable and mux select, including the ALU op encoding, and waits on memory ready handshakes. It also keeps cycle and retired-instruction counters.

Parameters:
CNT_W, 32, width of cycle_cnt and instret_cnt (wrap modulo 2^CNT_W)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk
ins  input  32  instruction word from fetch memory
fetch_ready  input  1  ins valid this cycle
dmem_ready  input  1  data memory access completes this cycle
zero  input  1  ALU zero flag
imem_req  output  1  instruction fetch request
ir_we  output  1  instruction register load strobe
pc_we  output  1  PC update enable
pc_src  output  2  00 PC+4, 01 branch target, 10 jal target
RegWrite  output  1  register file write enable
ALUSrc  output  1  0 rd2, 1 immediate
alu_op  output  3  000 and, 001 or, 010 add, 110 sub, 111 slt
mem_read  output  1  data memory read strobe
mem_write  output  1  data memory write strobe
wb_sel  output  2  00 ALU result, 01 memory data, 10 PC+4
illegal  output  1  sticky illegal-instruction flag
cycle_cnt  output  CNT_W  cycles since reset, excluding TRAP
instret_cnt  output  CNT_W  retired instructions

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP; encoding is free.
- Reset: state=FETCH, internal IR=0, counters=0, illegal=0. All outputs are 0 except imem_req, which is 1 because of FETCH. Reset has priority over every event, including a pending memory wait. It takes effect at the sampling edge.
- Outputs are decoded from the state and the latched IR (Moore). Exceptions: ir_we depends on fetch_ready; pc_we/pc_src in branch EXEC and in MEM depend on zero/dmem_ready.
- FETCH: imem_req=1. Stay in FETCH while fetch_ready=0. When fetch_ready=1: ir_we=1, IR<=ins, go to DECODE.
- DECODE: one cycle, no strobes. An unsupported opcode/funct goes to TRAP; everything else goes to EXEC.
- Supported opcodes:
  - R 0110011: f3=000/f7=0 add; f3=000/f7=0100000 sub; f3=111/f7=0 and; f3=110/f7=0 or; f3=010/f7=0 slt.
  - I 0010011: f3 000 addi, 111 andi, 110 ori, 010 slti.
  - Load 0000011: f3=010 only. Store 0100011: f3=010 only.
  - Branch 1100011: f3 000 beq, 001 bne.
  - JAL 1101111.
  - Anything else is illegal.
- EXEC:
  - R/I: drive alu_op; ALUSrc=0 for R, 1 for I; go to WB.
  - Load/store: alu_op=010, ALUSrc=1; go to MEM.
  - Branch: alu_op=110, ALUSrc=0, pc_we=1. taken=zero XOR f3[0]. pc_src=01 if taken, else 00. Retire; go to FETCH.
  - JAL: RegWrite=1, wb_sel=10, pc_we=1, pc_src=10. Retire; go to FETCH.
- MEM: hold alu_op=010 and ALUSrc=1.
  - Load: mem_read=1 every cycle until dmem_ready=1, then go to WB.
  - Store: mem_write=1 until dmem_ready=1. In the dmem_ready cycle: pc_we=1, pc_src=00, retire, go to FETCH.
- WB: RegWrite=1, pc_we=1, pc_src=00, retire, go to FETCH.
  - Load: wb_sel=01.
  - R/I: wb_sel=00, with the EXEC alu_op/ALUSrc held so the ALU result stays stable.
- Strobes are exclusive: RegWrite, mem_read and mem_write are never asserted in the same cycle.
- TRAP: illegal=1. All enables/strobes are 0, imem_req=0, counters frozen. Only reset exits TRAP.
- Counters: cycle_cnt increments every non-TRAP cycle. instret_cnt increments on the edge ending a retire cycle. Both wrap at 2^CNT_W−1 to 0.
- Latency with zero wait states: R/I 4 cycles, load 5, store 4, branch 3, jal 3. Each fetch or data wait cycle adds one.

Test Plan:
- Reset, then ins=0x002081B3 (add x3,x1,x2) with fetch_ready=1 → cycles FETCH,DECODE,EXEC,WB; alu_op=010, ALUSrc=0 in EXEC/WB; RegWrite=1, wb_sel=00, pc_we=1 only in WB; instret_cnt=1, cycle_cnt=4.
- ins=0x0080A283 (lw x5,8(x1)), dmem_ready low 2 cycles → mem_read high exactly 3 cycles; then WB with wb_sel=01; 7 cycles total; instret +1.
- ins=0x00208463 (beq x1,x2,+8), zero=1 → EXEC asserts pc_we=1, pc_src=01, alu_op=110. Repeat with zero=0 → pc_src=00. 3 cycles each.
- fetch_ready held low 5 cycles after reset → imem_req stays 1, ir_we=0, cycle_cnt=5, instret_cnt=0.
- ins=0x00000000 → TRAP after DECODE; illegal=1 and stays 1; counters unchanged for 10 cycles; all strobes 0. Reset → illegal=0, FETCH.
- Store with dmem_ready=0, assert reset for one cycle mid-wait → next cycle mem_write=0, state FETCH, imem_req=1, both counters 0. Set CNT_W=4, run 16 cycles → cycle_cnt wraps 15→0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Datapath-side signal bundle of the multi-cycle control sequencer.
// master = sequencer (drives strobes/selects), slave = datapath/memories.
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      ins;
  logic             fetch_ready;
  logic             dmem_ready;
  logic             zero;
  logic             imem_req;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             RegWrite;
  logic             ALUSrc;
  logic [2:0]       alu_op;
  logic             mem_read;
  logic             mem_write;
  logic [1:0]       wb_sel;
  logic             illegal;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  ins, fetch_ready, dmem_ready, zero,
    output imem_req, ir_we, pc_we, pc_src, RegWrite, ALUSrc, alu_op,
           mem_read, mem_write, wb_sel, illegal, cycle_cnt, instret_cnt
  );

  modport slave (
    output ins, fetch_ready, dmem_ready, zero,
    input  imem_req, ir_we, pc_we, pc_src, RegWrite, ALUSrc, alu_op,
           mem_read, mem_write, wb_sel, illegal, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP,
// datapath strobes and ALU op, plus cycle and retired-instruction counters.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t           state_q, state_d;
  // Only opcode/funct3/funct7 are ever decoded, so only those fields are kept.
  logic [16:0]      ir_q, ir_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       f3_ok, is_r, is_i, is_ld, is_st, is_br, is_jal, legal;
  logic [2:0] f3_alu, alu_sel;
  logic       retire;

  logic       imem_req, ir_we, pc_we, reg_write, alu_src, mem_read, mem_write;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] alu_op;

  assign opc = ir_q[6:0];
  assign f3  = ir_q[9:7];
  assign f7  = ir_q[16:10];

  always_comb begin
    f3_ok  = 1'b1;
    f3_alu = 3'b010;
    case (f3)
      3'b000:  f3_alu = 3'b010;
      3'b111:  f3_alu = 3'b000;
      3'b110:  f3_alu = 3'b001;
      3'b010:  f3_alu = 3'b111;
      default: f3_ok  = 1'b0;
    endcase
  end

  assign is_r    = (opc == OP_R) && f3_ok &&
                   ((f7 == 7'b0000000) || ((f7 == 7'b0100000) && (f3 == 3'b000)));
  assign is_i    = (opc == OP_I) && f3_ok;
  assign is_ld   = (opc == OP_LD) && (f3 == 3'b010);
  assign is_st   = (opc == OP_ST) && (f3 == 3'b010);
  assign is_br   = (opc == OP_BR) && (f3[2:1] == 2'b00);
  assign is_jal  = (opc == OP_JAL);
  assign legal   = is_r | is_i | is_ld | is_st | is_br | is_jal;
  assign alu_sel = (is_r && f7[5]) ? 3'b110 : f3_alu;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retire    = 1'b0;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'b00;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    alu_op    = 3'b000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wb_sel    = 2'b00;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.fetch_ready) begin
          ir_we   = 1'b1;
          ir_d    = {bus.ins[31:25], bus.ins[14:12], bus.ins[6:0]};
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_r || is_i) begin
          alu_op  = alu_sel;
          alu_src = is_i;
          state_d = S_WB;
        end else if (is_ld || is_st) begin
          alu_op  = 3'b010;
          alu_src = 1'b1;
          state_d = S_MEM;
        end else if (is_br) begin
          alu_op  = 3'b110;
          pc_we   = 1'b1;
          pc_src  = (bus.zero ^ f3[0]) ? 2'b01 : 2'b00;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          reg_write = 1'b1;
          wb_sel    = 2'b10;
          pc_we     = 1'b1;
          pc_src    = 2'b10;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEM: begin
        alu_op    = 3'b010;
        alu_src   = 1'b1;
        mem_read  = is_ld;
        mem_write = is_st;
        if (bus.dmem_ready) begin
          if (is_ld) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_we     = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
        if (is_ld) begin
          wb_sel = 2'b01;
        end else begin
          // Hold the EXEC operand selection so the written ALU result is stable.
          alu_op  = alu_sel;
          alu_src = is_i;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  assign illegal_d = illegal_q | (state_d == S_TRAP);
  assign cyc_d     = (state_q != S_TRAP) ? cyc_q + CNT_W'(1) : cyc_q;
  assign ret_d     = ret_q + CNT_W'(retire);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      cyc_q     <= '0;
      ret_q     <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      cyc_q     <= cyc_d;
      ret_q     <= ret_d;
    end
  end

  assign bus.imem_req    = imem_req;
  assign bus.ir_we       = ir_we;
  assign bus.pc_we       = pc_we;
  assign bus.pc_src      = pc_src;
  assign bus.RegWrite    = reg_write;
  assign bus.ALUSrc      = alu_src;
  assign bus.alu_op      = alu_op;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.wb_sel      = wb_sel;
  assign bus.illegal     = illegal_q;
  assign bus.cycle_cnt   = cyc_q;
  assign bus.instret_cnt = ret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: vector table, hand-written corner sequences and
// random instructions checked against a per-instruction transaction model.
module tb_multicycle_ctrl;

  typedef struct {
    logic [31:0] ins;
    int          fw;
    int          dw;
    logic        z;
    int          cyc;
    logic [1:0]  pcs;
    logic [2:0]  alu;
    logic        asrc;
    logic [1:0]  wb;
    int          nrw;
    int          nmr;
    int          nmw;
    logic        chk_alu;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();
  multicycle_ctrl_if #(.CNT_W(4))  bus4 ();

  multicycle_ctrl #(.CNT_W(32)) dut  (.clk(clk), .reset(rst),  .bus(bus));
  multicycle_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .reset(rst4), .bus(bus4));

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_cyc = '0;
  logic [31:0] exp_ret = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.fetch_ready = 1'b0;
    bus.dmem_ready  = 1'b0;
    bus.zero        = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cyc = '0;
    exp_ret = '0;
  endtask

  function automatic vec_t mkv(logic [31:0] ins, int fw, int dw, logic z, int cyc,
                               logic [1:0] pcs, logic [2:0] alu, logic asrc,
                               logic [1:0] wb, int nrw, int nmr, int nmw,
                               logic chk_alu, logic ill);
    vec_t v;
    v.ins = ins; v.fw = fw; v.dw = dw; v.z = z; v.cyc = cyc; v.pcs = pcs;
    v.alu = alu; v.asrc = asrc; v.wb = wb; v.nrw = nrw; v.nmr = nmr;
    v.nmw = nmw; v.chk_alu = chk_alu; v.ill = ill;
    return v;
  endfunction

  // Instruction-level model: class, latency and strobe counts from the ISA rules.
  function automatic vec_t model(logic [31:0] ins, int fw, int dw, logic z);
    vec_t       v;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] code;
    logic       ok;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    v = mkv(ins, fw, dw, z, fw + 2, 2'b00, 3'b000, 1'b0, 2'b00, 0, 0, 0, 1'b0, 1'b1);
    ok = 1'b1;
    case (f3)
      3'b000:  code = 3'b010;
      3'b111:  code = 3'b000;
      3'b110:  code = 3'b001;
      3'b010:  code = 3'b111;
      default: begin code = 3'b000; ok = 1'b0; end
    endcase
    if (opc == 7'b0110011 && ok && f7 == 7'd0)
      v = mkv(ins, fw, dw, z, 4 + fw, 2'b00, code, 1'b0, 2'b00, 1, 0, 0, 1'b1, 1'b0);
    else if (opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'h20)
      v = mkv(ins, fw, dw, z, 4 + fw, 2'b00, 3'b110, 1'b0, 2'b00, 1, 0, 0, 1'b1, 1'b0);
    else if (opc == 7'b0010011 && ok)
      v = mkv(ins, fw, dw, z, 4 + fw, 2'b00, code, 1'b1, 2'b00, 1, 0, 0, 1'b1, 1'b0);
    else if (opc == 7'b0000011 && f3 == 3'b010)
      v = mkv(ins, fw, dw, z, 5 + fw + dw, 2'b00, 3'b000, 1'b0, 2'b01, 1, dw + 1, 0, 1'b0, 1'b0);
    else if (opc == 7'b0100011 && f3 == 3'b010)
      v = mkv(ins, fw, dw, z, 4 + fw + dw, 2'b00, 3'b000, 1'b0, 2'b00, 0, 0, dw + 1, 1'b0, 1'b0);
    else if (opc == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001))
      v = mkv(ins, fw, dw, z, 3 + fw, (z != f3[0]) ? 2'b01 : 2'b00, 3'b110, 1'b0,
              2'b00, 0, 0, 0, 1'b1, 1'b0);
    else if (opc == 7'b1101111)
      v = mkv(ins, fw, dw, z, 3 + fw, 2'b10, 3'b000, 1'b0, 2'b10, 1, 0, 0, 1'b0, 1'b0);
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int         mc, nrw, nmr, nmw, npw, nirw, nimr, nexcl, ncyc, nbad;
    logic [1:0] pcs, wbs;
    logic [2:0] alu;
    logic       asrc, memalu_ok, done;
    mc = 0; nrw = 0; nmr = 0; nmw = 0; npw = 0; nirw = 0; nimr = 0; nexcl = 0;
    ncyc = 0; nbad = 0; pcs = 2'b11; wbs = 2'b11; alu = 3'b101; asrc = 1'bx;
    memalu_ok = 1'b1; done = 1'b0;
    bus.zero = v.z;
    for (int k = 0; k < 80 && !done; k++) begin
      bus.ins         = (k <= v.fw) ? v.ins : $urandom;
      bus.fetch_ready = (k == v.fw) ? 1'b1 : ((k < v.fw) ? 1'b0 : 1'($urandom % 2));
      bus.dmem_ready  = (bus.mem_read || bus.mem_write) ? (mc == v.dw) : 1'($urandom % 2);
      #3;
      if (bus.mem_read || bus.mem_write) begin
        mc++;
        if (bus.alu_op !== 3'b010 || bus.ALUSrc !== 1'b1) memalu_ok = 1'b0;
      end
      nrw  += int'(bus.RegWrite);
      nmr  += int'(bus.mem_read);
      nmw  += int'(bus.mem_write);
      nirw += int'(bus.ir_we);
      nimr += int'(bus.imem_req);
      if (int'(bus.RegWrite) + int'(bus.mem_read) + int'(bus.mem_write) > 1) nexcl++;
      if (bus.RegWrite) wbs = bus.wb_sel;
      if (bus.illegal === 1'b1) begin
        done = 1'b1;
        ncyc = k;
      end else if (bus.pc_we === 1'b1) begin
        npw++;
        pcs  = bus.pc_src;
        alu  = bus.alu_op;
        asrc = bus.ALUSrc;
        ncyc = k + 1;
        done = 1'b1;
      end
      tick();
    end
    exp_cyc += 32'(v.cyc);
    if (!v.ill) exp_ret += 32'd1;
    chk({nm, ".done"}, 32'(done), 32'd1);
    chk({nm, ".cycles"}, 32'(ncyc), 32'(v.cyc));
    chk({nm, ".cycle_cnt"}, bus.cycle_cnt, exp_cyc);
    chk({nm, ".instret_cnt"}, bus.instret_cnt, exp_ret);
    chk({nm, ".ir_we_cycles"}, 32'(nirw), 32'd1);
    chk({nm, ".imem_req_cycles"}, 32'(nimr), 32'(v.fw + 1));
    chk({nm, ".exclusive"}, 32'(nexcl), 32'd0);
    if (!v.ill) begin
      chk({nm, ".pc_we_cycles"}, 32'(npw), 32'd1);
      chk({nm, ".pc_src"}, 32'(pcs), 32'(v.pcs));
      chk({nm, ".regwrite_cycles"}, 32'(nrw), 32'(v.nrw));
      chk({nm, ".mem_read_cycles"}, 32'(nmr), 32'(v.nmr));
      chk({nm, ".mem_write_cycles"}, 32'(nmw), 32'(v.nmw));
      if (v.nrw > 0) chk({nm, ".wb_sel"}, 32'(wbs), 32'(v.wb));
      if (v.chk_alu) chk({nm, ".alu"}, {28'd0, asrc, alu}, {28'd0, v.asrc, v.alu});
      if (v.nmr + v.nmw > 0) chk({nm, ".mem_alu"}, 32'(memalu_ok), 32'd1);
    end else begin
      for (int k = 0; k < 10; k++) begin
        bus.ins         = $urandom;
        bus.fetch_ready = 1'($urandom % 2);
        bus.dmem_ready  = 1'($urandom % 2);
        #3;
        if (bus.illegal !== 1'b1 || bus.imem_req || bus.ir_we || bus.pc_we ||
            bus.RegWrite || bus.mem_read || bus.mem_write) nbad++;
        tick();
      end
      chk({nm, ".trap_hold"}, 32'(nbad), 32'd0);
      chk({nm, ".trap_cycle_cnt"}, bus.cycle_cnt, exp_cyc);
      chk({nm, ".trap_instret"}, bus.instret_cnt, exp_ret);
      do_reset();
      #3;
      chk({nm, ".rst_illegal"}, 32'(bus.illegal), 32'd0);
      chk({nm, ".rst_imem_req"}, 32'(bus.imem_req), 32'd1);
      chk({nm, ".rst_cnts"}, bus.cycle_cnt | bus.instret_cnt, 32'd0);
      tick();
      exp_cyc = 32'd1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    vec_t        v;
    logic [6:0]  opcs[6];
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] ins;
    int          nbad;

    bus.ins = '0;
    bus4.ins = '0; bus4.fetch_ready = 1'b0; bus4.dmem_ready = 1'b0; bus4.zero = 1'b0;

    tbl.push_back(mkv(32'h002081B3, 0, 0, 1'b0, 4, 2'b00, 3'b010, 1'b0, 2'b00, 1, 0, 0, 1'b1, 1'b0));
    tbl.push_back(mkv(32'h0080A283, 0, 2, 1'b0, 7, 2'b00, 3'b000, 1'b0, 2'b01, 1, 3, 0, 1'b0, 1'b0));
    tbl.push_back(mkv(32'h00208463, 0, 0, 1'b1, 3, 2'b01, 3'b110, 1'b0, 2'b00, 0, 0, 0, 1'b1, 1'b0));
    tbl.push_back(mkv(32'h00208463, 0, 0, 1'b0, 3, 2'b00, 3'b110, 1'b0, 2'b00, 0, 0, 0, 1'b1, 1'b0));
    tbl.push_back(mkv(32'h00209463, 0, 0, 1'b1, 3, 2'b00, 3'b110, 1'b0, 2'b00, 0, 0, 0, 1'b1, 1'b0));
    tbl.push_back(mkv(32'h00209463, 1, 0, 1'b0, 4, 2'b01, 3'b110, 1'b0, 2'b00, 0, 0, 0, 1'b1, 1'b0));
    tbl.push_back(mkv(32'h0020A223, 1, 1, 1'b0, 6, 2'b00, 3'b000, 1'b0, 2'b00, 0, 0, 2, 1'b0, 1'b0));
    tbl.push_back(mkv(32'h402081B3, 2, 0, 1'b0, 6, 2'b00, 3'b110, 1'b0, 2'b00, 1, 0, 0, 1'b1, 1'b0));
    tbl.push_back(mkv(32'h00512093, 0, 0, 1'b0, 4, 2'b00, 3'b111, 1'b1, 2'b00, 1, 0, 0, 1'b1, 1'b0));
    tbl.push_back(mkv(32'h0020E1B3, 0, 0, 1'b0, 4, 2'b00, 3'b001, 1'b0, 2'b00, 1, 0, 0, 1'b1, 1'b0));
    tbl.push_back(mkv(32'h00F0F093, 0, 0, 1'b0, 4, 2'b00, 3'b000, 1'b1, 2'b00, 1, 0, 0, 1'b1, 1'b0));
    tbl.push_back(mkv(32'h010000EF, 0, 0, 1'b0, 3, 2'b10, 3'b000, 1'b0, 2'b10, 1, 0, 0, 1'b0, 1'b0));
    tbl.push_back(mkv(32'h00000000, 1, 0, 1'b0, 3, 2'b00, 3'b000, 1'b0, 2'b00, 0, 0, 0, 1'b0, 1'b1));
    tbl.push_back(mkv(32'h00209093, 0, 0, 1'b0, 2, 2'b00, 3'b000, 1'b0, 2'b00, 0, 0, 0, 1'b0, 1'b1));

    // Reset state and a five-cycle fetch stall.
    do_reset();
    #3;
    chk("reset.imem_req", 32'(bus.imem_req), 32'd1);
    chk("reset.outputs", {19'd0, bus.ir_we, bus.pc_we, bus.pc_src, bus.RegWrite, bus.ALUSrc,
        bus.alu_op, bus.mem_read, bus.mem_write, bus.wb_sel, bus.illegal}, 32'd0);
    chk("reset.counters", bus.cycle_cnt | bus.instret_cnt, 32'd0);
    nbad = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) #3;
      if (bus.imem_req !== 1'b1 || bus.ir_we !== 1'b0) nbad++;
      tick();
    end
    chk("stall.fetch_outputs", 32'(nbad), 32'd0);
    chk("stall.cycle_cnt", bus.cycle_cnt, 32'd5);
    chk("stall.instret_cnt", bus.instret_cnt, 32'd0);
    exp_cyc = 32'd5;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    opcs[0] = 7'b0110011; opcs[1] = 7'b0010011; opcs[2] = 7'b0000011;
    opcs[3] = 7'b0100011; opcs[4] = 7'b1100011; opcs[5] = 7'b1101111;
    for (int n = 0; n < 60; n++) begin
      int r;
      r   = int'($urandom % 8);
      opc = (r < 6) ? opcs[r] : ((r == 6) ? 7'b0110011 : 7'($urandom));
      f3  = 3'($urandom);
      f7  = ($urandom % 3 == 0) ? 7'($urandom) : (($urandom % 2 == 0) ? 7'h00 : 7'h20);
      if ((r == 2 || r == 3) && ($urandom % 4 != 0)) f3 = 3'b010;
      if (r == 4) f3 = 3'($urandom % 3);
      ins = {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), opc};
      v = model(ins, int'($urandom % 3), int'($urandom % 3), 1'($urandom % 2));
      run_vec(v, $sformatf("rnd%0d", n));
    end

    // Reset in the middle of a store's data-memory wait.
    bus.ins = 32'h0020A223;
    bus.fetch_ready = 1'b1;
    bus.dmem_ready = 1'b0;
    tick();
    bus.fetch_ready = 1'b0;
    tick();
    tick();
    #3;
    chk("midrst.mem_write_before", 32'(bus.mem_write), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #3;
    chk("midrst.mem_write_after", 32'(bus.mem_write), 32'd0);
    chk("midrst.imem_req", 32'(bus.imem_req), 32'd1);
    chk("midrst.counters", bus.cycle_cnt | bus.instret_cnt, 32'd0);

    // Narrow counter wraps 15 -> 0.
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    #3;
    chk("wrap.cnt15", 32'(bus4.cycle_cnt), 32'd15);
    tick();
    #3;
    chk("wrap.cnt0", 32'(bus4.cycle_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
